// File: rtl/spi_sched_pkg.sv
// spi_sched_pkg: shared types and constants for the SPI command scheduler.
//   state_e  - scheduler FSM states (IDLE, LAUNCH, WAIT, GAP)
//   CMD_W    - command / response word width
//   TMO_RSP  - response word returned when a transaction times out
package spi_sched_pkg;

    localparam int CMD_W = 16;
    localparam logic [CMD_W-1:0] TMO_RSP = 16'hDEAD;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_GAP    = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arb.sv
// rr_arb: combinational round-robin selector.
//   req     - request vector, one bit per requester
//   last    - index of the most recently served requester
//   win_oh  - one-hot winner (all zero when req is zero)
//   win_idx - index of the winner
// The search starts at last+1 and wraps, so the previous winner has the
// lowest priority.
module rr_arb #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [IDX_W-1:0]   win_idx
);

    int               pos;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        pos     = 0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            // last < NUM_REQ and k <= NUM_REQ, so one subtraction wraps it
            pos = int'(last) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            cand = IDX_W'(pos);
            if (!found && req[cand]) begin
                found        = 1'b1;
                win_oh[cand] = 1'b1;
                win_idx      = cand;
            end
        end
    end

endmodule

// File: rtl/spi_cmd_sched.sv
// spi_cmd_sched: shares one SPI master between NUM_REQ requesters.
//   clk, rst_n      - clock, asynchronous active-low reset
//   req, cmd_in     - per-requester request and 16-bit command (flattened)
//   gnt             - one-cycle one-hot pulse: command accepted
//   rsp_vld         - one-cycle one-hot pulse: rsp_data/rsp_err valid
//   rsp_data        - response word, held until the next rsp_vld
//   rsp_err         - 1 = transaction timed out
//   busy            - high whenever the scheduler is not in IDLE
//   wrt_cmd,command - start pulse and command word to the SPI master
//   done, resp      - completion pulse and response from the SPI master
// Build option: define SPI_SCHED_TIMEOUT_EN to add a WAIT watchdog that
// answers with rsp_err=1 / rsp_data=16'hDEAD after TMO_CYC cycles.
module spi_cmd_sched
    import spi_sched_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int GAP_CYC = 32,
    parameter int TMO_CYC = 2048
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [CMD_W*NUM_REQ-1:0] cmd_in,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       rsp_vld,
    output logic [CMD_W-1:0]         rsp_data,
    output logic                     rsp_err,
    output logic                     busy,
    output logic                     wrt_cmd,
    output logic [CMD_W-1:0]         command,
    input  logic                     done,
    input  logic [CMD_W-1:0]         resp
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // One counter times the GAP dwell and, when enabled, the WAIT watchdog.
    localparam int CNT_MAX = (GAP_CYC > TMO_CYC) ? GAP_CYC : TMO_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    // GAP_CYC=0 still spends one cycle in GAP.
    localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;
`ifdef SPI_SCHED_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);
`endif

    logic [CMD_W-1:0] cmd_arr [NUM_REQ];
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cmd
        assign cmd_arr[gi] = cmd_in[gi*CMD_W +: CMD_W];
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [NUM_REQ-1:0] own_q, own_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    logic [CMD_W-1:0]   data_q, data_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] vld_q, vld_d;
    logic               wrt_q, wrt_d;
    logic               busy_q, busy_d;
`ifdef SPI_SCHED_TIMEOUT_EN
    logic               err_q, err_d;
`endif

    logic [NUM_REQ-1:0] arb_oh;
    logic [IDX_W-1:0]   arb_idx;

    rr_arb #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req     (req),
        .last    (last_q),
        .win_oh  (arb_oh),
        .win_idx (arb_idx)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        own_d   = own_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        data_d  = data_q;
        gnt_d   = '0;
        vld_d   = '0;
        wrt_d   = 1'b0;
`ifdef SPI_SCHED_TIMEOUT_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // gnt/wrt_cmd are registered, so they appear in LAUNCH
                if (|req) begin
                    win_d   = arb_idx;
                    own_d   = arb_oh;
                    cmd_d   = cmd_arr[arb_idx];
                    gnt_d   = arb_oh;
                    wrt_d   = 1'b1;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                last_d  = win_q;
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done) begin
                    data_d  = resp;
                    vld_d   = own_q;
                    cnt_d   = '0;
                    state_d = ST_GAP;
`ifdef SPI_SCHED_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == TMO_LAST) begin
                    data_d  = TMO_RSP;
                    err_d   = 1'b1;
                    vld_d   = own_q;
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) state_d = ST_IDLE;
                else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= IDX_W'(NUM_REQ - 1);
            win_q   <= '0;
            own_q   <= '0;
            cnt_q   <= '0;
            cmd_q   <= '0;
            data_q  <= '0;
            gnt_q   <= '0;
            vld_q   <= '0;
            wrt_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SPI_SCHED_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            own_q   <= own_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            wrt_q   <= wrt_d;
            busy_q  <= busy_d;
`ifdef SPI_SCHED_TIMEOUT_EN
            err_q   <= err_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign rsp_vld  = vld_q;
    assign rsp_data = data_q;
    assign busy     = busy_q;
    assign wrt_cmd  = wrt_q;
    assign command  = cmd_q;
`ifdef SPI_SCHED_TIMEOUT_EN
    assign rsp_err  = err_q;
`else
    assign rsp_err  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_sched.sv
// tb_spi_cmd_sched: randomized bench for spi_cmd_sched.
// Requesters and an SPI master model drive the DUT; a transaction-level
// timeline model (arbitration edge, response edge, gap end) predicts every
// output on every clock edge.
module tb_spi_cmd_sched;

    localparam int N   = 3;
    localparam int GAP = 5;
    localparam int TMO = 64;
    localparam int G   = (GAP > 0) ? GAP : 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [16*N-1:0] cmd_in = '0;
    logic            done = 1'b0;
    logic [15:0]     resp = '0;
    logic [N-1:0]    gnt, rsp_vld;
    logic [15:0]     rsp_data, command;
    logic            rsp_err, busy, wrt_cmd;

    spi_cmd_sched #(.NUM_REQ(N), .GAP_CYC(GAP), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .cmd_in(cmd_in),
        .gnt(gnt), .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .wrt_cmd(wrt_cmd), .command(command),
        .done(done), .resp(resp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%h expected=%h", tag, n, got, exp);
        end
    endtask

    // ---------------- timeline model ----------------
    int           idle_from = 1;
    bit           in_txn = 0;
    int           arb_at = 0;
    int           m_w = 0;
    int           m_last = N - 1;
    logic [15:0]  m_cmd = '0, m_data = '0;
    logic         m_err = 1'b0;
    logic [N-1:0] e_gnt, e_vld;
    logic         e_wrt, e_busy;

    // ---------------- agents ----------------
    logic [N-1:0] pend = '0, blip = '0;
    logic [15:0]  pcmd [N];
    bit           hot = 0, init_phase = 1, stall = 0;
    int           quiet = 0;
    int           done_edge = -1;

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic model_eval();
        e_gnt = '0; e_vld = '0; e_wrt = 1'b0;
        if (!in_txn) begin
            if (n >= idle_from && req != '0) begin
                m_w = rr_pick(req, m_last);
                e_gnt[m_w] = 1'b1;
                e_wrt  = 1'b1;
                m_cmd  = cmd_in[m_w*16 +: 16];
                m_last = m_w;
                arb_at = n;
                in_txn = 1;
            end
        end else if (n >= arb_at + 2) begin
            if (done) begin
                e_vld[m_w] = 1'b1;
                m_data = resp; m_err = 1'b0;
                in_txn = 0; idle_from = n + G + 1;
            end
`ifdef SPI_SCHED_TIMEOUT_EN
            else if (n == arb_at + 1 + TMO) begin
                e_vld[m_w] = 1'b1;
                m_data = 16'hDEAD; m_err = 1'b1;
                in_txn = 0; idle_from = n + G + 1;
            end
`endif
        end
        e_busy = in_txn || (n < idle_from - 1);
    endtask

    task automatic check_outputs();
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("wrt_cmd", 32'(wrt_cmd), 32'(e_wrt));
        chk("rsp_vld", 32'(rsp_vld), 32'(e_vld));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("command", 32'(command), 32'(m_cmd));
        chk("rsp_data", 32'(rsp_data), 32'(m_data));
        chk("rsp_err", 32'(rsp_err), 32'(m_err));
    endtask

    task automatic prep_inputs();
        if (e_wrt) begin
            pend[m_w] = 1'b0;
            if (stall) done_edge = -1;
            else begin
                done_edge = arb_at + 1 + int'($urandom_range(1, 6));
`ifdef SPI_SCHED_TIMEOUT_EN
                if ($urandom_range(0, 3) == 0) done_edge = -1;
`endif
            end
        end
        for (int i = 0; i < N; i++) begin
            if (init_phase) continue;
            if (!pend[i]) begin
                if (hot || $urandom_range(0, 7) == 0) begin
                    pend[i] = 1'b1;
                    pcmd[i] = 16'($urandom);
                    blip[i] = !hot && ($urandom_range(0, 3) == 0);
                end
            end else if (!hot && (blip[i] || $urandom_range(0, 39) == 0)) begin
                pend[i] = 1'b0;
                blip[i] = 1'b0;
            end
        end
        for (int i = 0; i < N; i++)
            cmd_in[i*16 +: 16] = pend[i] ? pcmd[i] : 16'($urandom);
        req = (quiet > 0) ? '0 : pend;
        if (in_txn && n + 1 >= arb_at + 2) begin
            done = (n + 1 == done_edge);
            resp = init_phase ? 16'h1234 : 16'($urandom);
        end else begin
            done = (quiet > 0) || ($urandom_range(0, 3) == 0);
            resp = 16'($urandom);
        end
        if (quiet > 0) quiet--;
    endtask

    task automatic step();
        @(posedge clk);
        n++;
        model_eval();
        @(negedge clk);
        check_outputs();
        if (e_vld != '0) init_phase = 0;
        prep_inputs();
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_gnt"}, 32'(gnt), 32'd0);
        chk({pfx, "_wrt_cmd"}, 32'(wrt_cmd), 32'd0);
        chk({pfx, "_rsp_vld"}, 32'(rsp_vld), 32'd0);
        chk({pfx, "_rsp_data"}, 32'(rsp_data), 32'd0);
        chk({pfx, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({pfx, "_command"}, 32'(command), 32'd0);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) pcmd[i] = '0;
        repeat (2) @(negedge clk);
        chk_reset("rst");

        // first transaction: only requester 0, command A5C3, response 1234
        pcmd[0] = 16'hA5C3;
        pend    = 3'b001;
        req     = pend;
        cmd_in  = {16'h0000, 16'h0000, 16'hA5C3};
        done    = 1'b0;
        rst_n   = 1'b1;
        idle_from = n + 1;

        repeat (500) step();
        hot = 1;
        repeat (500) step();

        // reset while the SPI master is busy
        stall = 1;
        for (int k = 0; k < 300; k++) begin
            if (in_txn && n >= arb_at + 2) break;
            step();
        end
        chk("reach_wait", 32'(in_txn && n >= arb_at + 2), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset("rst_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("rst_hold");
        in_txn = 0; m_last = N - 1; m_cmd = '0; m_data = '0; m_err = 1'b0;
        done_edge = -1; stall = 0;
        idle_from = n + 1;
        // done pulses right after release must be ignored
        req   = '0;
        done  = 1'b1;
        quiet = 2;
        rst_n = 1'b1;

        hot = 0;
        repeat (400) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
